// File: rtl/or_reduce_pipe.sv
// Pipelined OR/AND/XOR reduction tree with valid/ready handshaking on both sides.
// Define OR_REDUCE_PIPE_STICKY_EN to add a sticky "result was 1" flag (sticky_clr/sticky_y).
module or_reduce_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
`ifdef OR_REDUCE_PIPE_STICKY_EN
  input  logic             sticky_clr,
  output logic             sticky_y,
`endif
  output logic             busy
);

  localparam int L = $clog2(WIDTH);
  localparam int S = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int P = 1 << L;

  logic [S-1:0] valid_q;
  logic [S-1:0] adv;
  logic [1:0]   op_q [S];
  logic [P-1:0] padded;

  function automatic logic combine(input logic a, input logic b, input logic [1:0] op);
    case (op)
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Unused leaves get the identity of the selected op so they never change the result.
  if (P > WIDTH) begin : g_pad
    assign padded = {{(P - WIDTH){in_op == 2'b01}}, in_data};
  end else begin : g_nopad
    assign padded = in_data;
  end

  // A stage may move when some stage at or after it is empty, or the output is taken.
  always_comb begin
    logic full;
    adv = '0;
    for (int s = 0; s < S; s++) begin
      full = 1'b1;
      for (int k = s; k < S; k++) full = full & valid_q[k];
      adv[s] = out_ready | ~full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        op_q[0]    <= in_op;
      end
      for (int s = 1; s < S; s++) begin
        if (adv[s]) begin
          valid_q[s] <= valid_q[s-1];
          op_q[s]    <= op_q[s-1];
        end
      end
    end
  end

  for (genvar s = 0; s < S; s++) begin : stg
    localparam int IN_LVL  = s * REG_EVERY;
    localparam int OUT_LVL = ((s + 1) * REG_EVERY < L) ? (s + 1) * REG_EVERY : L;
    localparam int IN_W    = P >> IN_LVL;
    localparam int OUT_W   = P >> OUT_LVL;

    logic [IN_W-1:0]  vec_in;
    logic [1:0]       op_in;
    logic [OUT_W-1:0] reduced;
    logic [OUT_W-1:0] data_q;

    if (s == 0) begin : g_first
      assign vec_in = padded;
      assign op_in  = in_op;
    end else begin : g_next
      assign vec_in = stg[s-1].data_q;
      assign op_in  = op_q[s-1];
    end

    // Levels are folded in place: node i of the next level overwrites slot i.
    always_comb begin
      logic [IN_W-1:0] t;
      t = vec_in;
      for (int k = 0; k < OUT_LVL - IN_LVL; k++) begin
        for (int i = 0; i < (IN_W >> (k + 1)); i++) begin
          t[i] = combine(t[2*i], t[2*i+1], op_in);
        end
      end
      reduced = t[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (adv[s]) data_q <= reduced;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[S-1];
  assign out_y     = valid_q[S-1] & stg[S-1].data_q[0];
  assign busy      = |valid_q;

`ifdef OR_REDUCE_PIPE_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (rst)                               sticky_q <= 1'b0;
    else if (out_valid & out_ready & out_y) sticky_q <= 1'b1;
    else if (sticky_clr)                    sticky_q <= 1'b0;
  end

  assign sticky_y = sticky_q;
`endif

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed self-checking bench for or_reduce_pipe (WIDTH=32 and WIDTH=15 instances).
// Sticky checks are compiled in when OR_REDUCE_PIPE_STICKY_EN is defined.
module tb_or_reduce_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid32, in_valid15;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        out_ready;
  logic        sticky_clr;
  logic        in_ready32, out_valid32, out_y32, busy32;
  logic        in_ready15, out_valid15, out_y15, busy15;
  logic        sticky_y32, sticky_y15;

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  or_reduce_pipe #(.WIDTH(32), .REG_EVERY(2)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid32), .out_ready(out_ready), .out_y(out_y32),
`ifdef OR_REDUCE_PIPE_STICKY_EN
    .sticky_clr(sticky_clr), .sticky_y(sticky_y32),
`endif
    .busy(busy32)
  );

  or_reduce_pipe #(.WIDTH(15), .REG_EVERY(2)) dut15 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid15), .in_ready(in_ready15), .in_data(in_data[14:0]), .in_op(in_op),
    .out_valid(out_valid15), .out_ready(out_ready), .out_y(out_y15),
`ifdef OR_REDUCE_PIPE_STICKY_EN
    .sticky_clr(sticky_clr), .sticky_y(sticky_y15),
`endif
    .busy(busy15)
  );

`ifndef OR_REDUCE_PIPE_STICKY_EN
  assign sticky_y32 = 1'b0;
  assign sticky_y15 = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [1:0] op, input logic [31:0] data);
    in_valid32 = valid;
    in_op      = op;
    in_data    = data;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  logic [1:0]  bp_op   [6];
  logic [31:0] bp_data [6];
  logic        bp_exp  [6];

  initial begin
    int idx;
    int oidx;
    tests_run    = 0;
    tests_failed = 0;
    bp_op   = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    bp_data = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
                32'h7FFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF};
    bp_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid15 = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    apply_stimulus(1'b0, 2'b00, 32'h0);
    tick; tick;
    check_output("rst_out_valid32", out_valid32, 1'b0);
    check_output("rst_busy32", busy32, 1'b0);
    check_output("rst_out_y32", out_y32, 1'b0);
    check_output("rst_out_valid15", out_valid15, 1'b0);
    check_output("rst_busy15", busy15, 1'b0);
    rst = 1'b0;
    tick;
    check_output("post_rst_in_ready32", in_ready32, 1'b1);
    check_output("post_rst_in_ready15", in_ready15, 1'b1);

    // Single OR token: result must appear exactly three cycles after acceptance.
    apply_stimulus(1'b1, 2'b00, 32'h0000_8000);
    #1;
    check_output("lat_accept", in_ready32, 1'b1);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0);
    check_output("lat_c1_valid", out_valid32, 1'b0);
    check_output("lat_c1_busy", busy32, 1'b1);
    tick;
    check_output("lat_c2_valid", out_valid32, 1'b0);
    tick;
    check_output("lat_c3_valid", out_valid32, 1'b1);
    check_output("lat_c3_y", out_y32, 1'b1);
    tick;
    check_output("lat_drained_valid", out_valid32, 1'b0);
    check_output("lat_drained_busy", busy32, 1'b0);

    // WIDTH=15: padding leaf must be the op identity.
    in_valid15 = 1'b1; in_op = 2'b01; in_data = 32'h0000_7FFF;
    tick;
    check_output("w15_c1_valid", out_valid15, 1'b0);
    in_op = 2'b01; in_data = 32'h0000_7FFE;
    tick;
    check_output("w15_and_7fff_valid", out_valid15, 1'b1);
    check_output("w15_and_7fff", out_y15, 1'b1);
    in_op = 2'b10; in_data = 32'h0000_7FFF;
    tick;
    check_output("w15_and_7ffe", out_y15, 1'b0);
    in_op = 2'b00; in_data = 32'h0000_0000;
    tick;
    check_output("w15_xor_7fff", out_y15, 1'b1);
    in_valid15 = 1'b0;
    tick;
    check_output("w15_or_0_valid", out_valid15, 1'b1);
    check_output("w15_or_0", out_y15, 1'b0);
    tick;
    check_output("w15_drained", out_valid15, 1'b0);

    // Back-to-back tokens of different ops.
    apply_stimulus(1'b1, 2'b10, 32'h0000_0007);
    tick;
    apply_stimulus(1'b1, 2'b00, 32'h0000_0000);
    tick;
    apply_stimulus(1'b1, 2'b01, 32'hFFFF_FFFF);
    tick;
    check_output("b2b_xor_valid", out_valid32, 1'b1);
    check_output("b2b_xor", out_y32, 1'b1);
    apply_stimulus(1'b1, 2'b11, 32'h8000_0000);
    tick;
    check_output("b2b_or_valid", out_valid32, 1'b1);
    check_output("b2b_or", out_y32, 1'b0);
    apply_stimulus(1'b0, 2'b00, 32'h0);
    tick;
    check_output("b2b_and_valid", out_valid32, 1'b1);
    check_output("b2b_and", out_y32, 1'b1);
    tick;
    check_output("b2b_op11_valid", out_valid32, 1'b1);
    check_output("b2b_op11", out_y32, 1'b1);
    tick;
    check_output("b2b_drained", out_valid32, 1'b0);

    // Backpressure: out_ready low for five cycles while six tokens stream in.
    idx  = 0;
    oidx = 0;
    for (int c = 0; c < 40 && oidx < 6; c++) begin
      out_ready = (c >= 5);
      if (idx < 6) apply_stimulus(1'b1, bp_op[idx], bp_data[idx]);
      else         apply_stimulus(1'b0, 2'b00, 32'h0);
      #1;
      if (c == 3) begin
        check_output("bp_in_ready_full", in_ready32, 1'b0);
        check_output("bp_accepted_count", idx, 3);
      end
      if (c == 3 || c == 4) begin
        check_output("bp_stall_valid", out_valid32, 1'b1);
        check_output("bp_stall_y", out_y32, 1'b1);
      end
      if (out_valid32 && out_ready) begin
        check_output("bp_order", out_y32, bp_exp[oidx]);
        oidx++;
      end
      if (in_valid32 && in_ready32) idx++;
      tick;
    end
    out_ready = 1'b1;
    apply_stimulus(1'b0, 2'b00, 32'h0);
    check_output("bp_results_seen", oidx, 6);
    check_output("bp_drained_busy", busy32, 1'b0);

    // Reset with three tokens in flight: nothing may emerge afterwards.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 2'b00, 32'h0000_0001);
      tick;
    end
    apply_stimulus(1'b0, 2'b00, 32'h0);
    rst = 1'b1;
    tick;
    check_output("midrst_out_valid", out_valid32, 1'b0);
    check_output("midrst_busy", busy32, 1'b0);
    check_output("midrst_out_y", out_y32, 1'b0);
    rst = 1'b0;
    #1;
    check_output("midrst_in_ready", in_ready32, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick;
      check_output("midrst_no_stale", out_valid32, 1'b0);
    end

`ifdef OR_REDUCE_PIPE_STICKY_EN
    check_output("sticky_after_rst", sticky_y32, 1'b0);
    apply_stimulus(1'b1, 2'b00, 32'h0000_0001);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0);
    tick; tick;
    check_output("sticky_before_xfer", sticky_y32, 1'b0);
    tick;
    check_output("sticky_set", sticky_y32, 1'b1);
    sticky_clr = 1'b1;
    tick;
    check_output("sticky_cleared", sticky_y32, 1'b0);
    apply_stimulus(1'b1, 2'b00, 32'h0000_0001);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0);
    tick; tick; tick;
    check_output("sticky_set_wins", sticky_y32, 1'b1);
    tick;
    check_output("sticky_clr_again", sticky_y32, 1'b0);
    sticky_clr = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
